// File: rtl/step_ramp_sequencer.sv
// step_ramp_sequencer
// Sequences one stepper move. A period counter produces one step per wrap,
// and the wrap limit is reprogrammed after every step to build an
// accel / cruise / decel (trapezoid or triangle) velocity profile. Each step
// advances a 4-coil full-step drive pattern.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   cmd_valid/cmd_ready move command handshake (see below)
//   cmd_dir             1 = forward (phase index +1), 0 = reverse
//   cmd_steps           number of steps in the move
//   cmd_start_period    slowest period, used at the start and end of the move
//   cmd_min_period      fastest (cruise) period, clamped to cmd_start_period
//   cmd_delta           period change per step while ramping
//   abort               end the current move at the next edge
//   step                one-cycle pulse per issued step
//   dir                 direction latched from the current or last move
//   coils               registered full-step coil pattern
//   busy                high whenever the sequencer is not idle
//   done                one-cycle pulse at the end of a move (normal or abort)
//   steps_left          steps not yet issued
//   state_dbg           current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only while idle; commands offered while busy are ignored
// and the cmd_* fields only need to be stable in the transfer cycle.
module step_ramp_sequencer #(
    parameter int CNT_W  = 24,
    parameter int STEP_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [CNT_W-1:0]  cmd_start_period,
    input  logic [CNT_W-1:0]  cmd_min_period,
    input  logic [CNT_W-1:0]  cmd_delta,
    input  logic              abort,
    output logic              step,
    output logic              dir,
    output logic [3:0]        coils,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [CNT_W-1:0]  period, period_n;
    logic [CNT_W-1:0]  start_p, start_n;
    logic [CNT_W-1:0]  min_p, min_n;
    logic [CNT_W-1:0]  delta_q, delta_n;
    logic [STEP_W-1:0] remaining, remaining_n;
    logic [STEP_W-1:0] ramp_cnt, ramp_cnt_n;
    logic [1:0]        phase, phase_n;
    logic              dir_n;
    logic              step_n;
    logic [3:0]        coils_n;

    logic              tick;
    logic [STEP_W-1:0] rem_dec;
    logic [STEP_W-1:0] ramp_inc;
    logic [CNT_W-1:0]  clamp_min;
    logic [CNT_W:0]    period_sum;
    logic [CNT_W:0]    min_plus_delta;
    logic [CNT_W-1:0]  period_inc;
    logic [CNT_W-1:0]  period_dec;

    assign tick     = (count >= period);
    assign rem_dec  = remaining - STEP_ONE;
    assign ramp_inc = ramp_cnt + STEP_ONE;

    // A requested cruise period slower than the start period is meaningless;
    // fall back to a constant-speed move at the start period.
    assign clamp_min = (cmd_min_period > cmd_start_period) ? cmd_start_period
                                                            : cmd_min_period;

    // Both period updates are done one bit wider so a large delta can neither
    // wrap past start_p when slowing down nor underflow below min_p when
    // speeding up.
    assign period_sum     = {1'b0, period} + {1'b0, delta_q};
    assign period_inc     = (period_sum > {1'b0, start_p}) ? start_p
                                                            : period_sum[CNT_W-1:0];
    assign min_plus_delta = {1'b0, min_p} + {1'b0, delta_q};
    assign period_dec     = ({1'b0, period} >= min_plus_delta) ? (period - delta_q)
                                                                : min_p;

    always_comb begin
        state_n     = state;
        count_n     = count;
        period_n    = period;
        start_n     = start_p;
        min_n       = min_p;
        delta_n     = delta_q;
        remaining_n = remaining;
        ramp_cnt_n  = ramp_cnt;
        phase_n     = phase;
        dir_n       = dir;
        step_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_n       = cmd_dir;
                    remaining_n = cmd_steps;
                    ramp_cnt_n  = '0;
                    count_n     = '0;
                    start_n     = cmd_start_period;
                    min_n       = clamp_min;
                    delta_n     = cmd_delta;
                    period_n    = cmd_start_period;
                    if (cmd_steps == '0)
                        state_n = S_DONE;
                    else if (cmd_delta == '0 || clamp_min == cmd_start_period)
                        state_n = S_CRUISE;
                    else
                        state_n = S_ACCEL;
                end
            end

            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (abort) begin
                    // Abort wins over a coincident tick: the step is dropped.
                    state_n = S_DONE;
                end else if (tick) begin
                    count_n     = '0;
                    step_n      = 1'b1;
                    phase_n     = dir ? (phase + 2'd1) : (phase - 2'd1);
                    remaining_n = rem_dec;
                    if (rem_dec == '0) begin
                        state_n = S_DONE;
                    end else begin
                        case (state)
                            S_ACCEL: begin
                                // ramp_cnt counts the steps spent speeding up,
                                // which is how many are needed to slow down.
                                ramp_cnt_n = ramp_inc;
                                if (rem_dec <= ramp_inc) begin
                                    state_n = S_DECEL;
                                end else begin
                                    period_n = period_dec;
                                    if (period_dec == min_p)
                                        state_n = S_CRUISE;
                                end
                            end
                            S_CRUISE: begin
                                if (rem_dec <= ramp_cnt) begin
                                    state_n  = S_DECEL;
                                    period_n = period_inc;
                                end
                            end
                            default: begin
                                period_n = period_inc;
                            end
                        endcase
                    end
                end else begin
                    count_n = count + CNT_ONE;
                end
            end

            S_DONE: state_n = S_IDLE;

            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        coils_n = 4'b1100;
        case (phase_n)
            2'd0: coils_n = 4'b1100;
            2'd1: coils_n = 4'b0110;
            2'd2: coils_n = 4'b0011;
            2'd3: coils_n = 4'b1001;
            default: coils_n = 4'b1100;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            count      <= '0;
            period     <= '0;
            start_p    <= '0;
            min_p      <= '0;
            delta_q    <= '0;
            remaining  <= '0;
            ramp_cnt   <= '0;
            phase      <= 2'd0;
            dir        <= 1'b0;
            step       <= 1'b0;
            coils      <= 4'b1100;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state      <= state_n;
            count      <= count_n;
            period     <= period_n;
            start_p    <= start_n;
            min_p      <= min_n;
            delta_q    <= delta_n;
            remaining  <= remaining_n;
            ramp_cnt   <= ramp_cnt_n;
            phase      <= phase_n;
            dir        <= dir_n;
            step       <= step_n;
            coils      <= coils_n;
            busy       <= (state_n != S_IDLE);
            done       <= (state_n == S_DONE);
            cmd_ready  <= (state_n == S_IDLE);
        end
    end

    assign steps_left = remaining;
    assign state_dbg  = state;

endmodule

// File: tb/tb_step_ramp_sequencer.sv
// Bench for step_ramp_sequencer: directed moves from the test plan followed by
// randomized moves, each checked cycle by cycle against a move-level profile
// model (expected step times, coil phase, done/busy windows).
module tb_step_ramp_sequencer;

    localparam int CNT_W  = 24;
    localparam int STEP_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_dir = 1'b0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [CNT_W-1:0]  cmd_start_period = '0;
    logic [CNT_W-1:0]  cmd_min_period = '0;
    logic [CNT_W-1:0]  cmd_delta = '0;
    logic              abort = 1'b0;
    logic              step;
    logic              dir;
    logic [3:0]        coils;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;
    logic [2:0]        state_dbg;

    int          n_checks = 0;
    int          n_errors = 0;
    int          model_phase = 0;
    logic [3:0]  coil_tab [4];
    logic [31:0] exp_q [$];

    step_ramp_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_dir          (cmd_dir),
        .cmd_steps        (cmd_steps),
        .cmd_start_period (cmd_start_period),
        .cmd_min_period   (cmd_min_period),
        .cmd_delta        (cmd_delta),
        .abort            (abort),
        .step             (step),
        .dir              (dir),
        .coils            (coils),
        .busy             (busy),
        .done             (done),
        .steps_left       (steps_left),
        .state_dbg        (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Move-level reference: cumulative step times (in cycles after the accept
    // edge) derived from the profile rules using plain integer arithmetic.
    task automatic build_profile(input int steps, input int start, input int minp,
                                 input int delta, output bit cruise);
        int mn, p, ramp, mode, t, left;
        exp_q.delete();
        cruise = 1'b0;
        mn = (minp > start) ? start : minp;
        p = start;
        ramp = 0;
        t = 0;
        mode = (delta == 0 || mn == start) ? 1 : 0;   // 0 speeding up, 1 cruise, 2 slowing
        if (steps > 0 && mode == 1) cruise = 1'b1;
        for (int k = 0; k < steps; k++) begin
            t += p + 1;
            exp_q.push_back(32'(t));
            left = steps - k - 1;
            if (left == 0) break;
            if (mode == 0) begin
                ramp++;
                if (left <= ramp) mode = 2;
                else begin
                    p = (p - delta < mn) ? mn : p - delta;
                    if (p == mn) begin
                        mode = 1;
                        cruise = 1'b1;
                    end
                end
            end else if (mode == 1) begin
                if (left <= ramp) begin
                    mode = 2;
                    p = (p + delta > start) ? start : p + delta;
                end
            end else begin
                p = (p + delta > start) ? start : p + delta;
            end
        end
    endtask

    // Driver + scoreboard for one move. abort_at = n aborts in the cycle of
    // the n-th tick (-1 for none). hold keeps cmd_valid high with different
    // fields for the whole move.
    task automatic run_move(input bit d, input int steps, input int start, input int minp,
                            input int delta, input int abort_at, input bit hold);
        int          done_off, limit, issued, obs_steps, tick_off;
        bit          exp_cruise, saw_cruise, exp_step;
        logic [31:0] offs [$];

        build_profile(steps, start, minp, delta, exp_cruise);
        offs = exp_q;
        if (steps == 0)       done_off = 0;
        else if (abort_at > 0) done_off = int'(offs[abort_at-1]);
        else                   done_off = int'(offs[offs.size()-1]);
        limit    = (abort_at > 0) ? abort_at - 1 : steps;
        tick_off = (abort_at > 0) ? int'(offs[abort_at-1]) - 1 : -1;

        check_eq("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_dir          = d;
        cmd_steps        = STEP_W'(steps);
        cmd_start_period = CNT_W'(start);
        cmd_min_period   = CNT_W'(minp);
        cmd_delta        = CNT_W'(delta);
        cmd_valid        = 1'b1;
        @(posedge clk);

        issued = 0;
        obs_steps = 0;
        saw_cruise = 1'b0;
        for (int off = 0; off <= done_off + 1; off++) begin
            @(negedge clk);
            if (off == 0) begin
                if (hold) begin
                    cmd_dir          = ~d;
                    cmd_steps        = STEP_W'(5);
                    cmd_start_period = CNT_W'(2);
                    cmd_min_period   = CNT_W'(1);
                    cmd_delta        = CNT_W'(1);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (off == done_off + 1) cmd_valid = 1'b0;

            exp_step = (exp_q.size() > 0) && (int'(exp_q[0]) == off) && (issued < limit);
            check_eq("step", 32'(step), 32'(exp_step));
            if (step) obs_steps++;
            if (exp_step) begin
                void'(exp_q.pop_front());
                issued++;
                model_phase = (model_phase + (d ? 1 : 3)) % 4;
            end
            check_eq("coils", 32'(coils), 32'(coil_tab[model_phase]));
            check_eq("steps_left", 32'(steps_left), 32'(steps - issued));
            check_eq("done", 32'(done), 32'(off == done_off));
            check_eq("busy", 32'(busy), 32'(off <= done_off));
            check_eq("cmd_ready", 32'(cmd_ready), 32'(off > done_off));
            check_eq("dir", 32'(dir), 32'(d));
            if (state_dbg == 3'd2) saw_cruise = 1'b1;
            abort = (off == tick_off);
        end
        abort = 1'b0;
        exp_q.delete();
        check_eq("step_total", 32'(obs_steps), 32'(limit));
        if (abort_at < 0 && steps > 0)
            check_eq("cruise_seen", 32'(saw_cruise), 32'(exp_cruise));
    endtask

    task automatic reset_mid_move();
        cmd_dir          = 1'b1;
        cmd_steps        = STEP_W'(8);
        cmd_start_period = CNT_W'(10);
        cmd_min_period   = CNT_W'(4);
        cmd_delta        = CNT_W'(2);
        cmd_valid        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_step", 32'(step), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_coils", 32'(coils), 32'(4'b1100));
        check_eq("rst_steps_left", 32'(steps_left), 32'd0);
        model_phase = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_step", 32'(step), 32'd0);
    endtask

    initial begin
        int st, sp, mp, dl, ab;
        bit dd, hd;

        coil_tab[0] = 4'b1100;
        coil_tab[1] = 4'b0110;
        coil_tab[2] = 4'b0011;
        coil_tab[3] = 4'b1001;

        // clock / reset
        #2 rst = 1'b0;
        #1;
        check_eq("reset_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset_step", 32'(step), 32'd0);
        check_eq("reset_dir", 32'(dir), 32'd0);
        check_eq("reset_coils", 32'(coils), 32'(4'b1100));
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_steps_left", 32'(steps_left), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // abort while idle does nothing
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_abort_busy", 32'(busy), 32'd0);
            check_eq("idle_abort_done", 32'(done), 32'd0);
            check_eq("idle_abort_ready", 32'(cmd_ready), 32'd1);
        end
        abort = 1'b0;

        run_move(1'b0, 3, 5, 0, 0, -1, 1'b0);   // constant speed, reverse
        reset_mid_move();
        run_move(1'b1, 8, 10, 4, 2, -1, 1'b0);  // trapezoid
        run_move(1'b1, 4, 10, 4, 2, -1, 1'b0);  // triangle
        run_move(1'b1, 8, 10, 4, 2, 3, 1'b0);   // abort on 3rd tick
        run_move(1'b1, 0, 10, 4, 2, -1, 1'b0);  // zero steps
        run_move(1'b1, 5, 3, 1, 1, -1, 1'b1);   // command held while busy
        run_move(1'b0, 6, 6, 9, 2, -1, 1'b0);   // min slower than start
        run_move(1'b1, 5, 0, 0, 3, -1, 1'b0);   // zero period, step every cycle

        for (int n = 0; n < 25; n++) begin
            dd = 1'($urandom_range(0, 1));
            hd = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 12);
            sp = $urandom_range(0, 20);
            mp = $urandom_range(0, 24);
            dl = $urandom_range(0, 6);
            ab = -1;
            if (st > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, st);
            run_move(dd, st, sp, mp, dl, ab, hd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/step_ramp_sequencer.md
Name: step_ramp_sequencer

Overview:
- Sequences a stepper move: accepts a move command, then drives an internal period counter that wraps when the count reaches a programmable limit, one step per wrap.
- Reprograms the counter limit after every step to give a trapezoidal or triangular accel/cruise/decel velocity profile.
- Advances the 4-coil full-step drive pattern on each step.
- Sits between the command/register interface and the coil drivers.

Parameters:
- CNT_W, 24, width of the period counter and of all period/delta inputs.
- STEP_W, 24, width of step_count and steps_left.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  move command present
- cmd_ready  output  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready
- cmd_dir  input  1  1 = forward (phase index +1), 0 = reverse
- cmd_steps  input  STEP_W  number of steps to issue
- cmd_start_period  input  CNT_W  slowest period (start and end of move)
- cmd_min_period  input  CNT_W  fastest (cruise) period
- cmd_delta  input  CNT_W  period change per step while ramping
- abort  input  1  stop the move immediately
- step  output  1  one-cycle pulse per step issued
- dir  output  1  latched direction of the current or last move
- coils  output  4  full-step coil drive pattern
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at the end of a move (normal end or abort)
- steps_left  output  STEP_W  remaining steps

Behaviour:
- Reset values: cmd_ready=1, step=0, dir=0, coils=4'b1100 (phase index 0), busy=0, done=0, steps_left=0. All internal registers are cleared.
- Reset is asynchronous and takes effect mid-move: the move is discarded.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- Accept (IDLE, cmd_valid=1), latches:
  - dir, remaining=cmd_steps, ramp_cnt=0, count=0.
  - Clamp: start_p = cmd_start_period; if cmd_min_period > cmd_start_period, min_p = start_p, else min_p = cmd_min_period.
  - period = start_p.
- Next state after accept:
  - cmd_steps=0 -> DONE, with no step pulse.
  - else if cmd_delta=0 or min_p=start_p -> CRUISE.
  - else -> ACCEL.
- Commands presented while busy are ignored; cmd_ready=0 in those states.
- Period counter (ACCEL/CRUISE/DECEL only):
  - count increments by 1 each cycle.
  - tick = (count >= period); on tick, count returns to 0.
  - Step-to-step interval is period+1 cycles. The first step comes start_p+1 cycles after the accept edge.
- On a tick, at the next edge:
  - step=1 for exactly one cycle.
  - phase index changes by ±1 mod 4 according to dir.
  - rem_n = remaining-1 is stored.
  - If rem_n=0 -> DONE. Otherwise the per-state rules below apply.
- ACCEL tick:
  - ramp_cnt += 1.
  - If rem_n <= new ramp_cnt -> DECEL, with period unchanged.
  - Else period = max(period-delta, min_p), computed without underflow. If that equals min_p -> CRUISE.
- CRUISE tick:
  - If rem_n <= ramp_cnt -> DECEL, with period = min(period+delta, start_p).
- DECEL tick:
  - period = min(period+delta, start_p).
  - Sums are computed CNT_W+1 wide before the compare.
- DONE:
  - done=1 for one cycle, then IDLE.
  - The final step pulse and done are high in the same cycle.
- abort:
  - In ACCEL/CRUISE/DECEL, abort -> DONE at the next edge. A tick in the same cycle is suppressed: no step, no phase change.
  - steps_left then holds the unissued count until the next accept.
  - abort in IDLE or DONE has no effect.
- Phase-to-coil map: index 0:1100, 1:0110, 2:0011, 3:1001.
  - The phase index persists across moves.
  - The coils output is registered.
- steps_left mirrors remaining.
- All outputs are registered.

Test Plan:
1. Reset mid-ACCEL (rst low for 3 cycles) -> immediately step=0, busy=0, coils=1100, steps_left=0; cmd_ready=1 after release.
2. Trapezoid: steps=8, start=10, min=4, delta=2, dir=1.
   - Step pulses at intervals 11,9,7,5,5,7,9,11 cycles from accept.
   - coils after the move = 1100 (8 steps mod 4).
   - done coincides with the 8th step; busy drops the next cycle.
3. Triangle: steps=4, start=10, min=4, delta=2.
   - Intervals 11,9,9,11; CRUISE is never entered; done after the 4th step.
4. Constant speed: steps=3, start=5, delta=0, dir=0.
   - Intervals 6,6,6.
   - coils sequence 1001, 0011, 0110 (reverse from index 0).
5. Abort asserted in the same cycle as the 3rd tick of case 2 -> no 3rd step, done next cycle, steps_left=6, phase index unchanged.
6. Zero steps and busy-ignore:
   - cmd_steps=0 -> done pulse 1 cycle after accept, no step.
   - cmd_valid held during a move -> not accepted until IDLE; cmd_ready=0 while busy.
